// File: rtl/otter_lsu_if.sv
// Word-wide memory bus between the OTTER load/store unit and memory.
// The request is held with stable address, byte enables and data until acknowledged.
interface otter_lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/otter_lsu.sv
// OTTER load/store unit: one bus access per START, DONE two cycles after START with zero waits
// (one cycle for illegal requests); the bus stalls it by withholding mem_ack, up to TIMEOUT cycles.
module otter_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   otter_lsu_if.master mem
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_flag_q, err_flag_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req_legal;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   // Decode of the incoming request; funct3[1:0] gives the access size.
   always_comb begin
      req_legal = 1'b0;
      req_be    = 4'b0000;
      req_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << addr[1:0];
            req_wdata = {4{wdata[7:0]}};
            req_legal = !we || !funct3[2];
         end
         2'b01: begin
            req_be    = 4'b0011 << {addr[1], 1'b0};
            req_wdata = {2{wdata[15:0]}};
            req_legal = !addr[0] && (!we || !funct3[2]);
         end
         2'b10: begin
            req_be    = 4'b1111;
            req_wdata = wdata;
            req_legal = (addr[1:0] == 2'b00) && !funct3[2];
         end
         default: begin
            req_legal = 1'b0;
         end
      endcase
   end

   // Load formatting works off the registered lane and size, not the live inputs.
   always_comb begin
      ld_byte = mem.mem_rdata[7:0];
      case (lane_q)
         2'd0:    ld_byte = mem.mem_rdata[7:0];
         2'd1:    ld_byte = mem.mem_rdata[15:8];
         2'd2:    ld_byte = mem.mem_rdata[23:16];
         default: ld_byte = mem.mem_rdata[31:24];
      endcase
      ld_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_flag_d  = err_flag_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      lane_d      = lane_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               we_d        = we;
               funct3_d    = funct3;
               lane_d      = addr[1:0];
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_be_d    = req_be;
               mem_wdata_d = req_wdata;
               cnt_d       = 8'd0;
               if (req_legal) begin
                  err_flag_d = 1'b0;
                  state_d    = S_REQ;
               end else begin
                  err_flag_d = 1'b1;
                  state_d    = S_FIN;
               end
            end
         end
         S_REQ: begin
            // An acknowledge on the last counted cycle beats the timeout.
            if (mem.mem_ack) begin
               if (!we_q) begin
                  rdata_d = ld_fmt;
               end
               state_d = S_FIN;
            end else if (cnt_q == CNT_LAST) begin
               err_flag_d = 1'b1;
               state_d    = S_FIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         err_flag_q  <= 1'b0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         lane_q      <= 2'b00;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_flag_q  <= err_flag_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         lane_q      <= lane_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // Every output decodes straight from flops, so nothing reaches them from the inputs.
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FIN);
   assign err           = (state_q == S_FIN) && err_flag_q;
   assign rdata         = rdata_q;
   assign mem.mem_req   = (state_q == S_REQ);
   assign mem.mem_we    = (state_q == S_REQ) && we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule
